// File: rtl/snake_pkg.sv
// snake_pkg: shared types and default grid constants for the snake body engine.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_e;

  localparam int DEF_H_LOGIC_WIDTH = 5;
  localparam int DEF_V_LOGIC_WIDTH = 5;
  localparam int DEF_H_LOGIC_MAX   = 31;
  localparam int DEF_V_LOGIC_MAX   = 23;
  localparam int DEF_DEPTH_WIDTH   = 7;
  localparam int DEF_INIT_LENGTH   = 3;
  localparam int DEF_INIT_HEADX    = 16;
  localparam int DEF_INIT_HEADY    = 12;

  // The opposite heading is the bitwise inverse of the encoding.
  function automatic dir_e reverse_dir(input dir_e d);
    return dir_e'(~d);
  endfunction

endpackage

// File: rtl/snake_tracker_if.sv
// snake_tracker_if: game-controller / renderer side bundle of the snake body engine.
interface snake_tracker_if #(
  parameter int H_LOGIC_WIDTH = 5,
  parameter int V_LOGIC_WIDTH = 5,
  parameter int DEPTH_WIDTH   = 7
);
  logic                     enb;
  logic                     step;
  logic [1:0]               direction;
  logic                     grow;
  logic [H_LOGIC_WIDTH-1:0] headx;
  logic [V_LOGIC_WIDTH-1:0] heady;
  logic [H_LOGIC_WIDTH-1:0] tailx;
  logic [V_LOGIC_WIDTH-1:0] taily;
  logic [DEPTH_WIDTH-1:0]   length;
  logic                     busy;
  logic                     alive;
  logic                     collide;
  logic [H_LOGIC_WIDTH-1:0] qx;
  logic [V_LOGIC_WIDTH-1:0] qy;
  logic                     q_hit;

  modport master (
    output enb, step, direction, grow, qx, qy,
    input  headx, heady, tailx, taily, length, busy, alive, collide, q_hit
  );

  modport slave (
    input  enb, step, direction, grow, qx, qy,
    output headx, heady, tailx, taily, length, busy, alive, collide, q_hit
  );
endinterface

// File: rtl/snake_seg_ram.sv
// snake_seg_ram: circular buffer of packed {y,x} segments; written at the head,
// read asynchronously one entry past the tail (the tail that follows a pop).
module snake_seg_ram #(
  parameter int DEPTH_WIDTH = 7,
  parameter int DATA_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] tail_next_o
);
  localparam int ENTRIES = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH-1:0] PTR_ZERO = {DEPTH_WIDTH{1'b0}};
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]  mem_q [ENTRIES];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_next_s;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
    else        wr_ptr_d = wr_ptr_q;
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    else        rd_ptr_d = rd_ptr_q;
  end

  // Pointers wrap naturally at 2^DEPTH_WIDTH; the length cap keeps one slot free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_next_s   = rd_ptr_q + PTR_ONE;
  assign tail_next_o = mem_q[rd_next_s];

endmodule

// File: rtl/snake_tracker.sv
// snake_tracker: snake body engine -- segment buffer, occupancy bitmap, INIT/RUN/DEAD FSM.
// Define SNAKE_WALL_WRAP_EN to make grid edges wrap instead of being fatal.
module snake_tracker
  import snake_pkg::*;
#(
  parameter int H_LOGIC_WIDTH = DEF_H_LOGIC_WIDTH,
  parameter int V_LOGIC_WIDTH = DEF_V_LOGIC_WIDTH,
  parameter int H_LOGIC_MAX   = DEF_H_LOGIC_MAX,
  parameter int V_LOGIC_MAX   = DEF_V_LOGIC_MAX,
  parameter int DEPTH_WIDTH   = DEF_DEPTH_WIDTH,
  parameter int INIT_LENGTH   = DEF_INIT_LENGTH,
  parameter int INIT_HEADX    = DEF_INIT_HEADX,
  parameter int INIT_HEADY    = DEF_INIT_HEADY
) (
  input logic            clk,
  input logic            rst,
  snake_tracker_if.slave bus
);
  localparam int H = H_LOGIC_WIDTH;
  localparam int V = V_LOGIC_WIDTH;
  localparam int D = DEPTH_WIDTH;
  localparam int SEG_W  = H + V;
  localparam int NCELLS = (H_LOGIC_MAX + 1) * (V_LOGIC_MAX + 1);
  localparam int IDX_W  = $clog2(NCELLS);

  localparam logic [H-1:0] XMAX       = H'(H_LOGIC_MAX);
  localparam logic [V-1:0] YMAX       = V'(V_LOGIC_MAX);
  localparam logic [H-1:0] X_ZERO     = {H{1'b0}};
  localparam logic [V-1:0] Y_ZERO     = {V{1'b0}};
  localparam logic [H-1:0] X_ONE      = {{(H-1){1'b0}}, 1'b1};
  localparam logic [V-1:0] Y_ONE      = {{(V-1){1'b0}}, 1'b1};
  localparam logic [H-1:0] HX0        = H'(INIT_HEADX);
  localparam logic [V-1:0] HY0        = V'(INIT_HEADY);
  localparam logic [H-1:0] INIT_TAILX = H'(INIT_HEADX - INIT_LENGTH + 1);
  localparam logic [D-1:0] LEN_ZERO   = {D{1'b0}};
  localparam logic [D-1:0] LEN_ONE    = {{(D-1){1'b0}}, 1'b1};
  localparam logic [D-1:0] LEN_CAP    = {D{1'b1}};
  localparam logic [D-1:0] LEN_INIT   = D'(INIT_LENGTH);

  state_e           state_q;
  dir_e             heading_q;
  logic [H-1:0]     headx_q, tailx_q;
  logic [V-1:0]     heady_q, taily_q;
  logic [D-1:0]     length_q;
  logic             busy_q, alive_q, collide_q, q_hit_q;
  logic [NCELLS-1:0] bitmap_q;

  dir_e             dir_req_s, eff_dir_d;
  logic [H-1:0]     nextx_d, initx_s;
  logic [V-1:0]     nexty_d;
  logic             at_edge_s, wall_fatal_s, pops_s, occ_s, tail_free_s, hit_s;
  logic             move_s, wr_en_s, pop_s, q_occ_s;
  logic [SEG_W-1:0] wr_data_s, tail_next_s;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [H-1:0] x, input logic [V-1:0] y);
    return IDX_W'(int'(y) * (H_LOGIC_MAX + 1) + int'(x));
  endfunction

  function automatic logic in_grid(input logic [H-1:0] x, input logic [V-1:0] y);
    return (int'(x) <= H_LOGIC_MAX) && (int'(y) <= V_LOGIC_MAX);
  endfunction

  // Effective heading (reversals ignored) and the candidate head cell.
  always_comb begin
    dir_req_s = dir_e'(bus.direction);
    eff_dir_d = heading_q;
    nextx_d   = headx_q;
    nexty_d   = heady_q;
    at_edge_s = 1'b0;
    if (dir_req_s == reverse_dir(heading_q)) eff_dir_d = heading_q;
    else                                     eff_dir_d = dir_req_s;
    case (eff_dir_d)
      DIR_UP: begin
        at_edge_s = (heady_q == Y_ZERO);
        nexty_d   = at_edge_s ? YMAX : heady_q - Y_ONE;
      end
      DIR_DOWN: begin
        at_edge_s = (heady_q == YMAX);
        nexty_d   = at_edge_s ? Y_ZERO : heady_q + Y_ONE;
      end
      DIR_LEFT: begin
        at_edge_s = (headx_q == X_ZERO);
        nextx_d   = at_edge_s ? XMAX : headx_q - X_ONE;
      end
      DIR_RIGHT: begin
        at_edge_s = (headx_q == XMAX);
        nextx_d   = at_edge_s ? X_ZERO : headx_q + X_ONE;
      end
      default: begin
        at_edge_s = 1'b0;
      end
    endcase
  end

  // Collision decision and buffer controls; the vacating tail cell is not an obstacle.
  always_comb begin
`ifdef SNAKE_WALL_WRAP_EN
    wall_fatal_s = 1'b0;
`else
    wall_fatal_s = at_edge_s;
`endif
    if (in_grid(nextx_d, nexty_d)) occ_s = bitmap_q[cell_idx(nextx_d, nexty_d)];
    else                           occ_s = 1'b0;
    if (in_grid(bus.qx, bus.qy)) q_occ_s = bitmap_q[cell_idx(bus.qx, bus.qy)];
    else                         q_occ_s = 1'b0;
    pops_s      = !bus.grow || (length_q == LEN_CAP);
    tail_free_s = (nextx_d == tailx_q) && (nexty_d == taily_q) && pops_s;
    hit_s       = wall_fatal_s || (occ_s && !tail_free_s);
    move_s      = (state_q == ST_RUN) && bus.enb && bus.step;
    initx_s     = INIT_TAILX + H'(length_q);
    if (state_q == ST_INIT) begin
      wr_en_s   = 1'b1;
      wr_data_s = {HY0, initx_s};
    end else begin
      wr_en_s   = move_s && !hit_s;
      wr_data_s = {nexty_d, nextx_d};
    end
    pop_s = move_s && !hit_s && pops_s;
  end

  snake_seg_ram #(
    .DEPTH_WIDTH (D),
    .DATA_WIDTH  (SEG_W)
  ) u_seg_ram (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wr_en_s),
    .pop_i       (pop_s),
    .wr_data_i   (wr_data_s),
    .tail_next_o (tail_next_s)
  );

  // Main FSM: builds the initial body, applies moves, latches death.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      heading_q <= DIR_RIGHT;
      headx_q   <= HX0;
      heady_q   <= HY0;
      tailx_q   <= INIT_TAILX;
      taily_q   <= HY0;
      length_q  <= LEN_ZERO;
      busy_q    <= 1'b1;
      alive_q   <= 1'b1;
      collide_q <= 1'b0;
      q_hit_q   <= 1'b0;
      bitmap_q  <= {NCELLS{1'b0}};
    end else begin
      collide_q <= 1'b0;
      q_hit_q   <= q_occ_s;
      case (state_q)
        ST_INIT: begin
          bitmap_q[cell_idx(initx_s, HY0)] <= 1'b1;
          length_q <= length_q + LEN_ONE;
          if (length_q == LEN_INIT - LEN_ONE) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (move_s) begin
            if (hit_s) begin
              alive_q   <= 1'b0;
              collide_q <= 1'b1;
              state_q   <= ST_DEAD;
            end else begin
              // Clear the old tail before setting the new head so a head
              // landing on the vacated cell keeps its bit.
              if (pops_s) begin
                bitmap_q[cell_idx(tailx_q, taily_q)] <= 1'b0;
                tailx_q <= tail_next_s[H-1:0];
                taily_q <= tail_next_s[SEG_W-1:H];
              end else begin
                length_q <= length_q + LEN_ONE;
              end
              bitmap_q[cell_idx(nextx_d, nexty_d)] <= 1'b1;
              headx_q   <= nextx_d;
              heady_q   <= nexty_d;
              heading_q <= eff_dir_d;
            end
          end
        end
        ST_DEAD: begin
          state_q <= ST_DEAD;
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign bus.headx   = headx_q;
  assign bus.heady   = heady_q;
  assign bus.tailx   = tailx_q;
  assign bus.taily   = taily_q;
  assign bus.length  = length_q;
  assign bus.busy    = busy_q;
  assign bus.alive   = alive_q;
  assign bus.collide = collide_q;
  assign bus.q_hit   = q_hit_q;

endmodule

// File: tb/tb_snake_tracker.sv
// tb_snake_tracker: table-driven directed bench for snake_tracker, plus hand-written
// init, loop, edge and growth-cap sequences (second instance with DEPTH_WIDTH=3).
module tb_snake_tracker;
  localparam logic [1:0] DU = 2'b00;
  localparam logic [1:0] DR = 2'b01;
  localparam logic [1:0] DL = 2'b10;
  localparam logic [1:0] DD = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  snake_tracker_if #(.H_LOGIC_WIDTH(5), .V_LOGIC_WIDTH(5), .DEPTH_WIDTH(7)) bus ();
  snake_tracker_if #(.H_LOGIC_WIDTH(5), .V_LOGIC_WIDTH(5), .DEPTH_WIDTH(3)) sbus ();

  snake_tracker u_dut (.clk(clk), .rst(rst), .bus(bus));
  snake_tracker #(.DEPTH_WIDTH(3)) u_small (.clk(clk), .rst(rst), .bus(sbus));

  typedef struct {
    logic       enb;
    logic       step;
    logic [1:0] dir;
    logic       grow;
    logic [4:0] qx;
    logic [4:0] qy;
    int         hx, hy, tx, ty, len;
    logic       alive, col, qhit;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic e, input logic s, input logic [1:0] d, input logic g,
                              input int qx, input int qy, input int hx, input int hy,
                              input int tx, input int ty, input int len,
                              input logic al, input logic co, input logic qh);
    vec_t v;
    v.enb = e; v.step = s; v.dir = d; v.grow = g;
    v.qx = 5'(qx); v.qy = 5'(qy);
    v.hx = hx; v.hy = hy; v.tx = tx; v.ty = ty; v.len = len;
    v.alive = al; v.col = co; v.qhit = qh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic s, input logic [1:0] d, input logic g,
                       input int qx, input int qy);
    bus.enb = e; bus.step = s; bus.direction = d; bus.grow = g;
    bus.qx = 5'(qx); bus.qy = 5'(qy);
    @(posedge clk);
    #1;
    bus.step = 1'b0;
  endtask

  task automatic chk_core(input string tag, input int hx, input int hy, input int tx,
                          input int ty, input int len, input logic al, input logic co);
    chk({tag, "_headx"}, 32'(bus.headx), hx);
    chk({tag, "_heady"}, 32'(bus.heady), hy);
    chk({tag, "_tailx"}, 32'(bus.tailx), tx);
    chk({tag, "_taily"}, 32'(bus.taily), ty);
    chk({tag, "_length"}, 32'(bus.length), len);
    chk({tag, "_alive"}, 32'(bus.alive), 32'(al));
    chk({tag, "_collide"}, 32'(bus.collide), 32'(co));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive(1'b1, 1'b0, DR, 1'b0, 15, 12);
    drive(1'b1, 1'b0, DR, 1'b0, 15, 12);
    chk_core({tag, "_rst"}, 16, 12, 14, 12, 0, 1'b1, 1'b0);
    chk({tag, "_rst_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_rst_qhit"}, 32'(bus.q_hit), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, DR, 1'b0, 0, 0);
      chk({tag, "_init_len"}, 32'(bus.length), 32'(i));
      chk({tag, "_init_busy"}, 32'(bus.busy), (i < 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.enb = 1'b1; bus.step = 1'b0; bus.direction = DR; bus.grow = 1'b0;
    bus.qx = 5'd0; bus.qy = 5'd0;
    sbus.enb = 1'b1; sbus.step = 1'b0; sbus.direction = DR; sbus.grow = 1'b0;
    sbus.qx = 5'd0; sbus.qy = 5'd0;

    //          enb  step dir grow qx  qy  hx  hy  tx  ty len alive col qhit
    vecs[0]  = mk(1, 0, DR, 0, 15, 12, 16, 12, 14, 12, 3, 1, 0, 1);
    vecs[1]  = mk(1, 1, DR, 0, 14, 12, 17, 12, 15, 12, 3, 1, 0, 1);
    vecs[2]  = mk(1, 1, DR, 0, 14, 12, 18, 12, 16, 12, 3, 1, 0, 0);
    vecs[3]  = mk(1, 1, DR, 0, 17, 12, 19, 12, 17, 12, 3, 1, 0, 1);
    vecs[4]  = mk(1, 1, DR, 0,  0,  0, 20, 12, 18, 12, 3, 1, 0, 0);
    vecs[5]  = mk(1, 1, DR, 0, 20, 12, 21, 12, 19, 12, 3, 1, 0, 1);
    vecs[6]  = mk(1, 0, DR, 0, 14, 12, 21, 12, 19, 12, 3, 1, 0, 0);
    vecs[7]  = mk(1, 1, DL, 0, 21, 12, 22, 12, 20, 12, 3, 1, 0, 1);
    vecs[8]  = mk(0, 1, DR, 0, 19, 12, 22, 12, 20, 12, 3, 1, 0, 0);
    vecs[9]  = mk(1, 1, DR, 1, 23, 12, 23, 12, 20, 12, 4, 1, 0, 0);
    vecs[10] = mk(1, 1, DR, 1, 23, 12, 24, 12, 20, 12, 5, 1, 0, 1);
    vecs[11] = mk(1, 1, DU, 0, 24, 12, 24, 11, 21, 12, 5, 1, 0, 1);
    vecs[12] = mk(1, 1, DL, 0, 21, 12, 23, 11, 22, 12, 5, 1, 0, 1);
    vecs[13] = mk(1, 1, DD, 0, 23, 11, 23, 11, 22, 12, 5, 0, 1, 1);
    vecs[14] = mk(1, 1, DR, 0, 22, 12, 23, 11, 22, 12, 5, 0, 0, 1);

    do_reset("a");
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].enb, vecs[i].step, vecs[i].dir, vecs[i].grow,
            int'(vecs[i].qx), int'(vecs[i].qy));
      chk_core($sformatf("v%0d", i), vecs[i].hx, vecs[i].hy, vecs[i].tx, vecs[i].ty,
               vecs[i].len, vecs[i].alive, vecs[i].col);
      chk($sformatf("v%0d_qhit", i), 32'(bus.q_hit), 32'(vecs[i].qhit));
    end

    // Reset from DEAD, then a length-4 loop chasing its own vacating tail.
    do_reset("b");
    drive(1'b1, 1'b1, DR, 1'b1, 0, 0);
    chk_core("loop_grow", 17, 12, 14, 12, 4, 1'b1, 1'b0);
    drive(1'b1, 1'b1, DU, 1'b0, 0, 0);
    chk_core("loop_up", 17, 11, 15, 12, 4, 1'b1, 1'b0);
    drive(1'b1, 1'b1, DL, 1'b0, 0, 0);
    chk_core("loop_left", 16, 11, 16, 12, 4, 1'b1, 1'b0);
    drive(1'b1, 1'b1, DD, 1'b0, 0, 0);
    chk_core("loop_down", 16, 12, 17, 12, 4, 1'b1, 1'b0);
    drive(1'b1, 1'b0, DD, 1'b0, 16, 12);
    chk("loop_qhit_head", 32'(bus.q_hit), 32'd1);
    drive(1'b1, 1'b0, DD, 1'b0, 15, 12);
    chk("loop_qhit_old", 32'(bus.q_hit), 32'd0);

    // Right edge.
    do_reset("c");
    for (int i = 1; i <= 15; i++) begin
      drive(1'b1, 1'b1, DR, 1'b0, 0, 0);
      chk("edge_run_headx", 32'(bus.headx), 32'(16 + i));
    end
    drive(1'b1, 1'b1, DR, 1'b0, 0, 0);
`ifdef SNAKE_WALL_WRAP_EN
    chk_core("edge_wrap", 0, 12, 30, 12, 3, 1'b1, 1'b0);
`else
    chk_core("edge_wall", 31, 12, 29, 12, 3, 1'b0, 1'b1);
`endif

    // Reset again (DEAD in the default build); the small instance re-inits too.
    do_reset("d");
    bus.step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sbus.step = 1'b1;
      sbus.direction = DR;
      sbus.grow = (i < 6) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      sbus.step = 1'b0;
      chk($sformatf("cap%0d_len", i), 32'(sbus.length), (i < 4) ? 32'(4 + i) : 32'd7);
      chk($sformatf("cap%0d_tailx", i), 32'(sbus.tailx), (i < 4) ? 32'd14 : 32'(11 + i));
      chk($sformatf("cap%0d_headx", i), 32'(sbus.headx), 32'(17 + i));
      chk($sformatf("cap%0d_alive", i), 32'(sbus.alive), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
